// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_resolve_pkg : shared types for branch resolution (r1.0)  |
// +-----------------------------------------------------------------+
package branch_resolve_pkg;

  typedef logic [63:0] u64;

  typedef struct packed {
    logic valid;
    logic is_br;
    logic epoch;
    u64   pc;
    u64   pred_pc;
    logic taken;
    u64   target;
  } resolve_t;

  typedef struct packed {
    logic valid;
    u64   pc;
  } redirect_t;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_HOLD = 1'b1
  } br_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_resolve_if : resolve/redirect bundle between EX and IF   |
// +-----------------------------------------------------------------+
interface branch_resolve_if;
  import branch_resolve_pkg::*;

  logic res_valid;
  logic res_is_br;
  logic res_epoch;
  u64   res_pc;
  u64   res_pred_pc;
  logic res_taken;
  u64   res_target;
  logic redir_valid;
  logic redir_ready;
  u64   redir_pc;
  logic fetch_epoch;
  logic flush;

  modport master (
    output res_valid, res_is_br, res_epoch, res_pc, res_pred_pc, res_taken, res_target,
    output redir_ready,
    input  redir_valid, redir_pc, fetch_epoch, flush
  );

  modport slave (
    input  res_valid, res_is_br, res_epoch, res_pc, res_pred_pc, res_taken, res_target,
    input  redir_ready,
    output redir_valid, redir_pc, fetch_epoch, flush
  );

endinterface
`default_nettype wire

// File: rtl/branch_next_pc.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_next_pc : actual next PC and live-mispredict compare     |
// +-----------------------------------------------------------------+
module branch_next_pc
  import branch_resolve_pkg::*;
#(
  parameter int unsigned INSN_BYTES = 4
) (
  input  resolve_t res,
  input  logic     epoch,
  output u64       act,
  output logic     live,
  output logic     mis
);

  // Sequential add wraps naturally at 2^64.
  assign act  = res.taken ? res.target : res.pc + u64'(INSN_BYTES);
  assign live = res.valid & (res.epoch == epoch);
  assign mis  = live & (act != res.pred_pc);

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | branch_resolve : mispredict redirect, epoch, perf counters r1.0 |
// +-----------------------------------------------------------------+
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned INSN_BYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolve_if.slave  br,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);

  resolve_t  res;
  redirect_t redir;
  br_state_t state, state_nxt;
  u64        act;
  u64        redir_pc_q;
  logic      live, mis;
  logic      epoch_q, flush_q;

  assign res = '{valid:   br.res_valid,
                 is_br:   br.res_is_br,
                 epoch:   br.res_epoch,
                 pc:      br.res_pc,
                 pred_pc: br.res_pred_pc,
                 taken:   br.res_taken,
                 target:  br.res_target};

  branch_next_pc #(
    .INSN_BYTES (INSN_BYTES)
  ) u_next_pc (
    .res   (res),
    .epoch (epoch_q),
    .act   (act),
    .live  (live),
    .mis   (mis)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= BR_IDLE;
    else        state <= state_nxt;
  end

  // A live mispredict in HOLD only comes from new-epoch work, so it re-arms HOLD.
  always_comb begin
    state_nxt   = state;
    redir.valid = (state == BR_HOLD);
    redir.pc    = redir_pc_q;
    case (state)
      BR_IDLE: if (mis) state_nxt = BR_HOLD;
      BR_HOLD: begin
        if (mis)                 state_nxt = BR_HOLD;
        else if (br.redir_ready) state_nxt = BR_IDLE;
      end
      default: state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      redir_pc_q    <= '0;
      epoch_q       <= 1'b0;
      flush_q       <= 1'b0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      flush_q       <= mis;
      perf_branches <= perf_branches + CNT_W'(live & res.is_br);
      perf_mispred  <= perf_mispred + CNT_W'(mis);
      if (mis) begin
        redir_pc_q <= act;
        epoch_q    <= ~epoch_q;
      end
    end
  end

  assign br.redir_valid = redir.valid;
  assign br.redir_pc    = redir.pc;
  assign br.fetch_epoch = epoch_q;
  assign br.flush       = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_branch_resolve : directed + random checks vs reference model |
// +-----------------------------------------------------------------+
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] perf_branches, perf_mispred;

  always #5 clk = ~clk;

  branch_resolve_if bif ();

  branch_resolve #(
    .CNT_W      (32),
    .INSN_BYTES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .br            (bif.slave),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  int total = 0;
  int bad   = 0;

  logic        m_epoch = 1'b0;
  logic        m_hold  = 1'b0;
  logic        m_flush = 1'b0;
  logic [63:0] m_pc    = '0;
  logic [31:0] m_br    = '0;
  logic [31:0] m_mis   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic isbr, input logic ep, input logic [63:0] pc,
                       input logic [63:0] pred, input logic tk, input logic [63:0] tgt,
                       input logic rdy);
    bif.res_valid   = v;
    bif.res_is_br   = isbr;
    bif.res_epoch   = ep;
    bif.res_pc      = pc;
    bif.res_pred_pc = pred;
    bif.res_taken   = tk;
    bif.res_target  = tgt;
    bif.redir_ready = rdy;
  endtask

  // Reference: apply the resolution rules for the inputs seen at this edge.
  task automatic model_edge();
    logic        live, mis;
    logic [63:0] act;
    if (!reset) begin
      m_epoch = 1'b0; m_hold = 1'b0; m_flush = 1'b0;
      m_pc = '0; m_br = '0; m_mis = '0;
    end else begin
      act  = bif.res_taken ? bif.res_target : bif.res_pc + 64'd4;
      live = bif.res_valid && (bif.res_epoch == m_epoch);
      mis  = live && (act != bif.res_pred_pc);
      if (live && bif.res_is_br) m_br++;
      if (mis) m_mis++;
      m_flush = mis;
      if (mis) begin
        m_pc    = act;
        m_epoch = ~m_epoch;
        m_hold  = 1'b1;
      end else if (m_hold && bif.redir_ready) begin
        m_hold = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("redir_valid", bif.redir_valid, m_hold);
    chk("redir_pc", bif.redir_pc, m_pc);
    chk("fetch_epoch", bif.fetch_epoch, m_epoch);
    chk("flush", bif.flush, m_flush);
    chk("perf_branches", perf_branches, m_br);
    chk("perf_mispred", perf_mispred, m_mis);
  endtask

  task automatic step(input logic v, input logic isbr, input logic ep, input logic [63:0] pc,
                      input logic [63:0] pred, input logic tk, input logic [63:0] tgt,
                      input logic rdy);
    drive(v, isbr, ep, pc, pred, tk, tgt, rdy);
    tick();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    logic [63:0] pc, tgt, pred, act;
    logic        tk, ep;

    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_redir_valid", bif.redir_valid, 1'b0);
    chk("reset_epoch", bif.fetch_epoch, 1'b0);
    reset = 1'b1;

    // Correct prediction
    step(1'b1, 1'b1, m_epoch, 64'h8000_0000, 64'h8000_0004, 1'b0, '0, 1'b1);
    chk("ok_branches", perf_branches, 32'd1);
    chk("ok_flush", bif.flush, 1'b0);

    // Mispredict with ready already high
    step(1'b1, 1'b1, m_epoch, 64'h8000_0010, 64'h8000_0014, 1'b1, 64'h8000_0100, 1'b1);
    chk("mis_valid", bif.redir_valid, 1'b1);
    chk("mis_pc", bif.redir_pc, 64'h8000_0100);
    chk("mis_flush", bif.flush, 1'b1);
    chk("mis_epoch", bif.fetch_epoch, 1'b1);
    idle(1'b1);
    chk("mis_done", bif.redir_valid, 1'b0);
    chk("mis_count", perf_mispred, 32'd1);

    // Stalled redirect with stale mispredicts during HOLD
    step(1'b1, 1'b1, m_epoch, 64'h8000_0020, 64'h8000_0024, 1'b1, 64'h8000_0200, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, ~m_epoch, 64'h9000_0000, 64'h1234, 1'b1, 64'h9999_0000, 1'b0);
      chk("stall_valid", bif.redir_valid, 1'b1);
      chk("stall_pc", bif.redir_pc, 64'h8000_0200);
      chk("stall_flush", bif.flush, 1'b0);
      chk("stall_mispred", perf_mispred, 32'd2);
    end
    idle(1'b1);
    idle(1'b1);
    chk("stall_done", bif.redir_valid, 1'b0);

    // Sequential PC wraps to zero
    step(1'b1, 1'b1, m_epoch, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, '0, 1'b1);
    chk("wrap_flush", bif.flush, 1'b0);
    chk("wrap_mispred", perf_mispred, 32'd2);

    // Reset while holding a redirect
    step(1'b1, 1'b1, m_epoch, 64'h8000_0040, 64'h8000_0044, 1'b1, 64'h8000_0400, 1'b0);
    chk("pre_rst_valid", bif.redir_valid, 1'b1);
    reset = 1'b0;
    idle(1'b0);
    chk("rst_valid", bif.redir_valid, 1'b0);
    chk("rst_epoch", bif.fetch_epoch, 1'b0);
    chk("rst_branches", perf_branches, 32'd0);
    reset = 1'b1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      pc   = {$urandom, $urandom} & ~64'h3;
      tgt  = {$urandom, $urandom} & ~64'h3;
      tk   = 1'($urandom_range(0, 1));
      act  = tk ? tgt : pc + 64'd4;
      pred = ($urandom_range(0, 1) == 0) ? act : {$urandom, $urandom};
      ep   = ($urandom_range(0, 3) == 0) ? ~m_epoch : m_epoch;
      reset = ($urandom_range(0, 63) != 0);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ep, pc, pred, tk, tgt,
           1'($urandom_range(0, 1)));
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
